nibble_serial_comp_ctrl: RTL and testbench

//  Sequencer that compares two wide unsigned operands MSB-first, one 4-bit nibble per cycle.

---
 rtl/nibble_serial_comp_ctrl.sv | 138 +++++++++++++
 tb/tb_nibble_serial_comp_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/nibble_serial_comp_ctrl.sv
// Serial MSB-first comparator sequencer driving one external 4-bit magnitude comparator.
// Optional feature: define EARLY_EXIT_EN to finish on the first mismatching nibble.
module nibble_serial_comp_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [3:0]           cmp_a,
    output logic [3:0]           cmp_b,
    input  logic                 cmp_x,
    input  logic                 cmp_y,
    input  logic                 cmp_z,
    output logic                 busy,
    output logic                 done,
    output logic                 eq,
    output logic                 gt,
    output logic                 lt
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [W-1:0]       r_a, r_b, w_a_next, w_b_next;
    logic [IDX_W-1:0]   r_idx, w_idx_next;
    logic               r_mis, w_mis_next;
    logic               r_eq, r_gt, r_lt;
    logic               w_eq_next, w_gt_next, w_lt_next;

    logic [3:0]         w_nib_a [NIBBLES];
    logic [3:0]         w_nib_b [NIBBLES];
    logic               w_first_mis;
    logic               w_last;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi = gi + 1) begin : g_nib
            assign w_nib_a[gi] = r_a[gi*4 +: 4];
            assign w_nib_b[gi] = r_b[gi*4 +: 4];
        end
    endgenerate

    // A==B decodes first; A<B is implied by a mismatch without A>B, so cmp_z is redundant.
    logic w_unused_z;
    assign w_unused_z = cmp_z;

    assign w_first_mis = (r_state == S_RUN) && !cmp_x && !r_mis;
`ifdef EARLY_EXIT_EN
    assign w_last = (r_idx == '0) || w_first_mis;
`else
    assign w_last = (r_idx == '0);
`endif

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_idx_next   = r_idx;
        w_mis_next   = r_mis;
        w_eq_next    = r_eq;
        w_gt_next    = r_gt;
        w_lt_next    = r_lt;
        cmp_a        = 4'd0;
        cmp_b        = 4'd0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_next     = a;
                    w_b_next     = b;
                    w_idx_next   = IDX_W'(NIBBLES - 1);
                    w_mis_next   = 1'b0;
                    w_eq_next    = 1'b0;
                    w_gt_next    = 1'b0;
                    w_lt_next    = 1'b0;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                cmp_a = w_nib_a[r_idx];
                cmp_b = w_nib_b[r_idx];
                if (w_first_mis) begin
                    w_mis_next = 1'b1;
                    w_gt_next  = cmp_y;
                    w_lt_next  = !cmp_y;
                end
                if (w_last) begin
                    w_state_next = S_DONE;
                    if (!r_mis && cmp_x)
                        w_eq_next = 1'b1;
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_mis   <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_idx   <= w_idx_next;
            r_mis   <= w_mis_next;
            r_eq    <= w_eq_next;
            r_gt    <= w_gt_next;
            r_lt    <= w_lt_next;
        end
    end

    assign eq = r_eq;
    assign gt = r_gt;
    assign lt = r_lt;
endmodule

// File: tb/tb_nibble_serial_comp_ctrl.sv
// Bench for nibble_serial_comp_ctrl with a behavioural comparator and a result/latency model.
// Follows EARLY_EXIT_EN when compiled with that macro.
module tb_nibble_serial_comp_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [3:0]   cmp_a, cmp_b;
    logic         cmp_x, cmp_y, cmp_z;
    logic         busy, done, eq, gt, lt;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_comp_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_z(cmp_z),
        .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    always #5 clk = ~clk;

    // The external 4-bit magnitude comparator
    assign cmp_x = (cmp_a == cmp_b);
    assign cmp_y = (cmp_a >  cmp_b);
    assign cmp_z = (cmp_a <  cmp_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef EARLY_EXIT_EN
        for (int i = 0; i < N; i++)
            if (((x >> (4*(N-1-i))) & 16'hF) != ((y >> (4*(N-1-i))) & 16'hF))
                return i + 1;
`endif
        return N;
    endfunction

    // One operation; optional second start raised in compare cycle restart_k (ignored by design).
    task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int restart_k, input string tag);
        int lat;
        logic [3:0] na, nb;
        lat = exp_latency(ta, tb_v);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < lat; k++) begin
            na = 4'((ta >> (4*(N-1-k))) & 16'hF);
            nb = 4'((tb_v >> (4*(N-1-k))) & 16'hF);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done_early"}, 32'(done), 32'd0);
            check({tag, "_cmp_a"}, 32'(cmp_a), 32'(na));
            check({tag, "_cmp_b"}, 32'(cmp_b), 32'(nb));
            if (k == restart_k) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_cmp_idle"}, 32'({cmp_a, cmp_b}), 32'd0);
        check({tag, "_res"}, 32'({eq, gt, lt}),
              32'({ta == tb_v, ta > tb_v, ta < tb_v}));
        $display("op %s a=%h b=%h lat=%0d eq=%0b gt=%0b lt=%0b", tag, ta, tb_v, lat, eq, gt, lt);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        // 1. reset and quiet idle
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out", 32'({busy, done, eq, gt, lt}), 32'd0);
        check("rst_cmp", 32'({cmp_a, cmp_b}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_no_done", 32'(done), 32'd0);
        end
        // 2. equal operands with result hold
        do_cmp(16'h1234, 16'h1234, -1, "eq");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("eq_hold", 32'({done, eq, gt, lt}), 32'b0100);
        end
        // 3, 4. gt on MSB nibble, lt on LSB nibble
        do_cmp(16'hA000, 16'h9FFF, -1, "gt_msb");
        do_cmp(16'h00FE, 16'h00FF, -1, "lt_lsb");
        // 5. restart during RUN is ignored
        do_cmp(16'h0001, 16'h0002, 1, "restart");
        // 6. reset mid-run aborts without done
        @(negedge clk);
        a = 16'h5555; b = 16'h5554; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", 32'({busy, done, eq, gt, lt}), 32'd0);
        check("abort_cmp", 32'({cmp_a, cmp_b}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        do_cmp(16'h5555, 16'h5554, -1, "after_abort");
        // randomized operations, biased toward shared high nibbles
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            case (i % 3)
                0: rb = W'($urandom);
                1: rb = ra;
                default: begin
                    rb = ra;
                    rb[4*$urandom_range(N-1, 0) +: 4] = 4'($urandom);
                end
            endcase
            do_cmp(ra, rb, -1, "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
